mxu_feeder: RTL and testbench

- Transmit side of the systolic MXU edge interface.
- Accepts one pair of DIM x DIM operand matrices (A, B) over a valid/ready handshake and streams them into the array edges with diagonal skew.
  - West edge row i receives A[i][k] at step i+k.
  - North edge column j receives B[k][j] at step j+k.
- After a configurable drain period, it pulses done so the consumer can sample the array accumulators.

---
 rtl/mxu_pkg.sv | 30 +++
 rtl/mxu_skew_lane.sv | 33 +++
 rtl/mxu_feeder.sv | 127 ++++++++++++
 tb/tb_mxu_feeder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mxu_pkg.sv
// Shared types and helpers for the MXU edge feeder: FSM state, element type and
// the diagonal-skew index calculation used by every edge lane.
package mxu_pkg;

  localparam int DIM_DEFAULT   = 8;
  localparam int WIDTH_DEFAULT = 4;

  typedef logic [WIDTH_DEFAULT-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic        hit;
    logic [15:0] idx;
  } skew_t;

  // Lane `lane` carries element (t - lane) of its vector at step t, when that index exists.
  function automatic skew_t skew_index(input logic [15:0] t, input logic [15:0] lane,
                                       input logic [15:0] dim);
    skew_t r;
    r.hit = (t >= lane) && ((t - lane) < dim);
    r.idx = t - lane;
    return r;
  endfunction

endpackage

// File: rtl/mxu_skew_lane.sv
// One edge lane: decides whether the current feed step lands on this lane and
// selects the matching element from the lane's operand vector.
module mxu_skew_lane
  import mxu_pkg::*;
#(
  parameter int DIM   = DIM_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int LANE  = 0,
  parameter int TW    = 4
) (
  input  logic [TW-1:0]        t_i,
  input  logic                 active_i,
  input  logic                 stall_i,
  input  logic [DIM*WIDTH-1:0] elems_i,
  output logic                 valid_o,
  output logic [WIDTH-1:0]     data_o
);

  skew_t sk;

  // Data ignores stall so the edge holds its value while the step is frozen.
  always_comb begin
    sk     = skew_index(16'(t_i), 16'(LANE), 16'(DIM));
    data_o = '0;
    for (int k = 0; k < DIM; k++) begin
      if (active_i && sk.hit && (sk.idx == 16'(k))) begin
        data_o = elems_i[k*WIDTH +: WIDTH];
      end
    end
    valid_o = active_i && sk.hit && !stall_i;
  end

endmodule

// File: rtl/mxu_feeder.sv
// Transmit side of the systolic MXU edge: captures an A/B operand pair, streams
// it diagonally skewed into the west/north edges, drains, then pulses done.
module mxu_feeder
  import mxu_pkg::*;
#(
  parameter int DIM          = DIM_DEFAULT,
  parameter int WIDTH        = WIDTH_DEFAULT,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIM*DIM*WIDTH-1:0] in_a,
  input  logic [DIM*DIM*WIDTH-1:0] in_b,
  input  logic                     stall,
  output logic [DIM*WIDTH-1:0]     west_data,
  output logic [DIM-1:0]           west_valid,
  output logic [DIM*WIDTH-1:0]     north_data,
  output logic [DIM-1:0]           north_valid,
  output logic                     busy,
  output logic                     done,
  output feeder_state_t            dbg_state
);

  localparam int TW = $clog2(2*DIM);
  localparam int DW = $clog2(DRAIN_CYCLES+1);
  localparam int MW = DIM*DIM*WIDTH;
  localparam int LW = DIM*WIDTH;

  feeder_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [MW-1:0] a_q, a_d, b_q, b_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  // Handshake: a pair transfers on any edge where in_valid && in_ready; in_ready
  // is high exactly in IDLE (including the done cycle) and never depends on in_valid.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    drain_d = drain_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          t_d     = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (!stall) begin
          if (t_q == TW'(2*DIM-2)) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (drain_q == DW'(DRAIN_CYCLES-1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    logic [LW-1:0] col;
    for (genvar k = 0; k < DIM; k++) begin : g_col
      assign col[k*WIDTH +: WIDTH] = b_q[(k*DIM+g)*WIDTH +: WIDTH];
    end

    mxu_skew_lane #(.DIM(DIM), .WIDTH(WIDTH), .LANE(g), .TW(TW)) u_west (
      .t_i      (t_q),
      .active_i (state_q == FEED),
      .stall_i  (stall),
      .elems_i  (a_q[g*LW +: LW]),
      .valid_o  (west_valid[g]),
      .data_o   (west_data[g*WIDTH +: WIDTH])
    );

    mxu_skew_lane #(.DIM(DIM), .WIDTH(WIDTH), .LANE(g), .TW(TW)) u_north (
      .t_i      (t_q),
      .active_i (state_q == FEED),
      .stall_i  (stall),
      .elems_i  (col),
      .valid_o  (north_valid[g]),
      .data_o   (north_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_mxu_feeder.sv
// Randomized bench for mxu_feeder: random operands, in_valid and stall, checked
// every cycle against a job-position reference model, plus a mid-feed reset abort.
module tb_mxu_feeder;
  import mxu_pkg::*;

  localparam int D  = 4;
  localparam int W  = 4;
  localparam int DR = 3;
  localparam int NV = D*D*W;
  localparam int EV = D*W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [NV-1:0] in_a, in_b;
  logic          stall;
  logic [EV-1:0] west_data, north_data;
  logic [D-1:0]  west_valid, north_valid;
  logic          busy, done;
  feeder_state_t dbg_state;

  always #5 clk = ~clk;

  mxu_feeder #(.DIM(D), .WIDTH(W), .DRAIN_CYCLES(DR)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .stall       (stall),
    .west_data   (west_data),
    .west_valid  (west_valid),
    .north_data  (north_data),
    .north_valid (north_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a job is a count of unstalled cycles since acceptance.
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int            m_pos  = 0;
  logic [NV-1:0] m_a, m_b;
  int            jobs_done = 0;
  bit            aborted   = 1'b0;

  function automatic logic [W-1:0] elem(input logic [NV-1:0] v, input int r, input int c);
    return v[(r*D+c)*W +: W];
  endfunction

  task automatic check_outputs();
    logic [EV-1:0] ew, en;
    logic [D-1:0]  ewv, env;
    int t;
    ew = '0; en = '0; ewv = '0; env = '0;
    if (m_busy && m_pos < 2*D-1) begin
      t = m_pos;
      for (int i = 0; i < D; i++) begin
        if (t >= i && t - i < D) begin
          ew[i*W +: W] = elem(m_a, i, t - i);
          en[i*W +: W] = elem(m_b, t - i, i);
          ewv[i] = !stall;
          env[i] = !stall;
        end
      end
    end
    check_eq("west_data",   64'(west_data),   64'(ew));
    check_eq("west_valid",  64'(west_valid),  64'(ewv));
    check_eq("north_data",  64'(north_data),  64'(en));
    check_eq("north_valid", 64'(north_valid), 64'(env));
    check_eq("in_ready",    64'(in_ready),    64'(!m_busy));
    check_eq("busy",        64'(busy),        64'(m_busy));
    check_eq("done",        64'(done),        64'(m_done));
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (!m_busy) begin
      if (in_valid) begin
        m_a = in_a; m_b = in_b; m_busy = 1'b1; m_pos = 0;
      end
    end else if (!stall) begin
      m_pos++;
      if (m_pos == 2*D-1+DR) begin
        m_busy = 1'b0; m_done = 1'b1; jobs_done++;
      end
    end
  endtask

  task automatic drive_random();
    in_valid = ($urandom_range(0, 2) != 0);
    stall    = ($urandom_range(0, 3) == 0);
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; in_a = '0; in_b = '0;
    @(negedge clk); #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("ready_after_reset", 64'(in_ready), 64'd1);

    // Directed first job: fixed ramp operands, no stall.
    in_valid = 1'b1; stall = 1'b0;
    for (int k = 0; k < D*D; k++) begin
      in_a[k*W +: W] = W'(k);
      in_b[k*W +: W] = W'(15 - k);
    end
    @(posedge clk); model_step();
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 2*D+DR+2; c++) begin
      #1 check_outputs();
      @(posedge clk); model_step();
      @(negedge clk);
    end

    for (int c = 0; c < 900; c++) begin
      drive_random();
      #1 check_outputs();
      if (!aborted && c > 60 && m_busy && m_pos == 1) begin
        aborted = 1'b1;
        reset = 1'b1;
        #1;
        m_busy = 1'b0; m_done = 1'b0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1 check_outputs();
        check_eq("ready_after_abort", 64'(in_ready), 64'd1);
      end
      @(posedge clk); model_step();
      @(negedge clk);
    end

    in_valid = 1'b0; stall = 1'b0;
    for (int c = 0; c < 4*D+DR+4; c++) begin
      #1 check_outputs();
      @(posedge clk); model_step();
      @(negedge clk);
    end
    check_eq("idle_at_end", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
